// File: rtl/ifm_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifm_scan_if
//  Description : Control/bus bundle between the IFM scan controller, the IFM
//                memory, the window buffer and the PE-side consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifm_scan_if #(
    parameter int IDX_W = 8
) ();
    logic             start;
    logic             hold;
    logic             rd_en;
    logic [IDX_W-1:0] rd_row;
    logic [IDX_W-1:0] rd_col;
    logic [2:0]       ifm_read;
    logic             win_valid;
    logic [IDX_W-1:0] win_row;
    logic [IDX_W-1:0] win_col;
    logic             busy;
    logic             done;

    // Host / surrounding datapath side
    modport master (
        output start, hold,
        input  rd_en, rd_row, rd_col, ifm_read,
        input  win_valid, win_row, win_col, busy, done
    );

    // Scan controller side
    modport slave (
        input  start, hold,
        output rd_en, rd_row, rd_col, ifm_read,
        output win_valid, win_row, win_col, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ifm_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifm_scan_ctrl
//  Description : Serpentine 3x3-window scan controller for an input feature
//                map. Issues window fetches to a 1-cycle-latency memory and
//                drives the shift commands of the window buffer, plus a
//                2-cycle delayed window-valid / coordinate stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifm_scan_ctrl #(
    parameter int IFM_W = 8,
    parameter int IFM_H = 8,
    parameter int IDX_W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ifm_scan_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [2:0] c_CMD_ALL   = 3'b111;
    localparam logic [2:0] c_CMD_RIGHT = 3'b001;
    localparam logic [2:0] c_CMD_DOWN  = 3'b010;
    localparam logic [2:0] c_CMD_LEFT  = 3'b100;
    localparam logic [2:0] c_CMD_KEEP  = 3'b000;

    localparam logic [IDX_W-1:0] c_COL_LAST = IDX_W'(IFM_W - 3);
    localparam logic [IDX_W-1:0] c_ROW_LAST = IDX_W'(IFM_H - 3);
    localparam logic [IDX_W-1:0] c_ONE      = IDX_W'(1);

    logic [1:0]       r_state;
    logic             r_drain_cnt;

    // Position and command of the next window to fetch
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;
    logic             r_dir_left;
    logic [2:0]       r_cmd;

    // Stage 1: aligned with memory data
    logic             r_p1_valid;
    logic             r_p1_last;
    logic [2:0]       r_p1_cmd;
    logic [IDX_W-1:0] r_p1_row;
    logic [IDX_W-1:0] r_p1_col;

    // Stage 2: aligned with the window buffer contents
    logic             r_win_valid;
    logic             r_done;
    logic [IDX_W-1:0] r_win_row;
    logic [IDX_W-1:0] r_win_col;

    logic             w_fetch;
    logic             w_row_end;
    logic             w_last;

    assign w_fetch   = (r_state == c_ISSUE) && !bus.hold;
    assign w_row_end = r_dir_left ? (r_col == '0) : (r_col == c_COL_LAST);
    assign w_last    = w_row_end && (r_row == c_ROW_LAST);

    // Scan sequencing: issue fetches, then let the 2-stage pipeline empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_drain_cnt <= 1'b0;
                    if (bus.start) begin
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_drain_cnt <= 1'b0;
                    if (w_fetch && w_last) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (r_drain_cnt) begin
                        r_state     <= c_IDLE;
                        r_drain_cnt <= 1'b0;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_drain_cnt <= 1'b0;
                end
            endcase
        end
    end

    // Serpentine position update; rewinds to (0,0) once the last window is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_dir_left <= 1'b0;
            r_cmd      <= c_CMD_ALL;
        end else if (w_fetch) begin
            if (w_last) begin
                r_row      <= '0;
                r_col      <= '0;
                r_dir_left <= 1'b0;
                r_cmd      <= c_CMD_ALL;
            end else if (w_row_end) begin
                r_row      <= r_row + c_ONE;
                r_dir_left <= !r_dir_left;
                r_cmd      <= c_CMD_DOWN;
            end else if (r_dir_left) begin
                r_col      <= r_col - c_ONE;
                r_cmd      <= c_CMD_LEFT;
            end else begin
                r_col      <= r_col + c_ONE;
                r_cmd      <= c_CMD_RIGHT;
            end
        end
    end

    // Stage 1: command and coordinates of the fetch issued last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_cmd   <= c_CMD_KEEP;
            r_p1_row   <= '0;
            r_p1_col   <= '0;
        end else begin
            r_p1_valid <= w_fetch;
            r_p1_last  <= w_fetch && w_last;
            r_p1_cmd   <= w_fetch ? r_cmd : c_CMD_KEEP;
            r_p1_row   <= w_fetch ? r_row : '0;
            r_p1_col   <= w_fetch ? r_col : '0;
        end
    end

    // Stage 2: window now present at the buffer outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_done      <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= r_p1_valid;
            r_done      <= r_p1_last;
            r_win_row   <= r_p1_row;
            r_win_col   <= r_p1_col;
        end
    end

    assign bus.rd_en     = w_fetch;
    assign bus.rd_row    = r_row;
    assign bus.rd_col    = r_col;
    assign bus.ifm_read  = r_p1_cmd;
    assign bus.win_valid = r_win_valid;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ifm_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifm_scan_ctrl
//  Description : Self-checking bench for ifm_scan_ctrl. Per-cycle vector
//                table on a 5x4 map, reset/abort sequence, and a scoreboard
//                with memory + window-buffer model on 3x5 and 8x8 maps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifm_scan_ctrl;

    localparam logic [2:0] ALL = 3'b111, RIGHT = 3'b001, DOWN = 3'b010, LEFT = 3'b100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifm_scan_if #(.IDX_W(8)) bus_a ();
    ifm_scan_if #(.IDX_W(8)) bus_b ();
    ifm_scan_if #(.IDX_W(8)) bus_c ();

    ifm_scan_ctrl #(.IFM_W(5), .IFM_H(4), .IDX_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ifm_scan_ctrl #(.IFM_W(3), .IFM_H(5), .IDX_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    ifm_scan_ctrl #(.IFM_W(8), .IFM_H(8), .IDX_W(8)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start, hold;
        logic       rd_en;
        int         rd_row, rd_col;
        logic [2:0] ifm;
        logic       wv;
        int         wr, wc;
        logic       busy, done;
    } vec_t;

    vec_t vec [24];

    function automatic vec_t mk(input logic st, input logic hd, input logic en, input int rr, input int rc,
                                input logic [2:0] ifm, input logic wv, input int wr, input int wc,
                                input logic bsy, input logic dn);
        vec_t v;
        v.start = st; v.hold = hd; v.rd_en = en; v.rd_row = rr; v.rd_col = rc;
        v.ifm = ifm; v.wv = wv; v.wr = wr; v.wc = wc; v.busy = bsy; v.done = dn;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] row;
        logic [7:0] col;
    } exp_t;

    exp_t        cmd_q [2][$];
    exp_t        win_q [2][$];
    int          win_cnt [2];
    int          done_cnt [2];
    int          done_a = 0;
    int          bad_b = 0;
    logic [71:0] mem_d [2];
    logic [7:0]  wbuf [2][3][3];

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    function automatic logic [71:0] pack_win(input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[71 - 24*i - 8*j -: 8] = pix(r + i, c + j);
        return v;
    endfunction

    // Independent serpentine model: expected command/window stream
    task automatic push_scan(input int id, input int w, input int h);
        exp_t e;
        for (int r = 0; r < h - 2; r++) begin
            for (int k = 0; k < w - 2; k++) begin
                e.row = 8'(r);
                e.col = 8'((r % 2 == 0) ? k : (w - 3 - k));
                if (r == 0 && k == 0)  e.cmd = ALL;
                else if (k == 0)       e.cmd = DOWN;
                else if (r % 2 == 0)   e.cmd = RIGHT;
                else                   e.cmd = LEFT;
                cmd_q[id].push_back(e);
                win_q[id].push_back(e);
            end
        end
    endtask

    task automatic sb_step(input int id, input logic rd_en, input logic [7:0] rd_row, input logic [7:0] rd_col,
                           input logic [2:0] ifm, input logic wv, input logic [7:0] wr, input logic [7:0] wc,
                           input logic dn);
        exp_t e;
        check("legal_code", id, 32'(ifm inside {3'b000, ALL, RIGHT, DOWN, LEFT}), 32'd1);
        if (ifm != 3'b000) begin
            if (cmd_q[id].size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_cmd_unexpected[%0d]: got %0h, expected none", id, ifm);
            end else begin
                e = cmd_q[id].pop_front();
                check("sb_cmd", id, 32'(ifm), 32'(e.cmd));
            end
        end
        if (wv) begin
            win_cnt[id]++;
            if (win_q[id].size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_win_unexpected[%0d]: got (%0d,%0d), expected none", id, wr, wc);
            end else begin
                e = win_q[id].pop_front();
                check("sb_win_row", id, 32'(wr), 32'(e.row));
                check("sb_win_col", id, 32'(wc), 32'(e.col));
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        check("sb_pixel", id, 32'(wbuf[id][i][j]), 32'(pix(int'(e.row) + i, int'(e.col) + j)));
            end
        end
        if (dn) begin
            done_cnt[id]++;
            check("sb_done_on_last", id, 32'(win_q[id].size()), 32'd0);
            check("sb_done_with_valid", id, 32'(wv), 32'd1);
        end
        // Window buffer shifts on the command aligned with memory data
        case (ifm)
            ALL: for (int i = 0; i < 3; i++)
                     for (int j = 0; j < 3; j++) wbuf[id][i][j] = mem_d[id][71 - 24*i - 8*j -: 8];
            RIGHT: for (int i = 0; i < 3; i++) begin
                     wbuf[id][i][0] = wbuf[id][i][1];
                     wbuf[id][i][1] = wbuf[id][i][2];
                     wbuf[id][i][2] = mem_d[id][71 - 24*i - 16 -: 8];
                 end
            LEFT: for (int i = 0; i < 3; i++) begin
                     wbuf[id][i][2] = wbuf[id][i][1];
                     wbuf[id][i][1] = wbuf[id][i][0];
                     wbuf[id][i][0] = mem_d[id][71 - 24*i -: 8];
                 end
            DOWN: for (int j = 0; j < 3; j++) begin
                     wbuf[id][0][j] = wbuf[id][1][j];
                     wbuf[id][1][j] = wbuf[id][2][j];
                     wbuf[id][2][j] = mem_d[id][71 - 48 - 8*j -: 8];
                 end
            default: ;
        endcase
        // Memory with one-cycle read latency
        mem_d[id] = rd_en ? pack_win(int'(rd_row), int'(rd_col)) : '0;
        if (id == 0 && (ifm == RIGHT || ifm == LEFT)) bad_b++;
    endtask

    always @(negedge clk) begin
        sb_step(0, bus_b.rd_en, bus_b.rd_row, bus_b.rd_col, bus_b.ifm_read,
                bus_b.win_valid, bus_b.win_row, bus_b.win_col, bus_b.done);
        sb_step(1, bus_c.rd_en, bus_c.rd_row, bus_c.rd_col, bus_c.ifm_read,
                bus_c.win_valid, bus_c.win_row, bus_c.win_col, bus_c.done);
        if (bus_a.done) done_a++;
    end

    task automatic check_a_zero(input string nm);
        check({nm, "_rd_en"},   0, 32'(bus_a.rd_en), 0);
        check({nm, "_rd_row"},  0, 32'(bus_a.rd_row), 0);
        check({nm, "_rd_col"},  0, 32'(bus_a.rd_col), 0);
        check({nm, "_ifm"},     0, 32'(bus_a.ifm_read), 0);
        check({nm, "_wv"},      0, 32'(bus_a.win_valid), 0);
        check({nm, "_win_row"}, 0, 32'(bus_a.win_row), 0);
        check({nm, "_win_col"}, 0, 32'(bus_a.win_col), 0);
        check({nm, "_busy"},    0, 32'(bus_a.busy), 0);
        check({nm, "_done"},    0, 32'(bus_a.done), 0);
    endtask

    initial begin
        int done_ref;
        int wins_ref;
        logic seen_busy;

        // 5x4, no hold (rows 0..11); extra starts while busy must be ignored
        vec[0]  = mk(1,0, 0,0,0, 3'd0, 0,0,0, 0,0);
        vec[1]  = mk(0,0, 1,0,0, 3'd0, 0,0,0, 1,0);
        vec[2]  = mk(0,0, 1,0,1, ALL,  0,0,0, 1,0);
        vec[3]  = mk(0,0, 1,0,2, RIGHT,1,0,0, 1,0);
        vec[4]  = mk(1,0, 1,1,2, RIGHT,1,0,1, 1,0);
        vec[5]  = mk(0,0, 1,1,1, DOWN, 1,0,2, 1,0);
        vec[6]  = mk(0,0, 1,1,0, LEFT, 1,1,2, 1,0);
        vec[7]  = mk(0,0, 0,0,0, LEFT, 1,1,1, 1,0);
        vec[8]  = mk(1,0, 0,0,0, 3'd0, 1,1,0, 1,1);
        vec[9]  = mk(0,0, 0,0,0, 3'd0, 0,0,0, 0,0);
        vec[10] = mk(0,0, 0,0,0, 3'd0, 0,0,0, 0,0);
        vec[11] = mk(0,1, 0,0,0, 3'd0, 0,0,0, 0,0);
        // 5x4, hold for 2 cycles after the third fetch (rows 12..23)
        vec[12] = mk(1,0, 0,0,0, 3'd0, 0,0,0, 0,0);
        vec[13] = mk(0,0, 1,0,0, 3'd0, 0,0,0, 1,0);
        vec[14] = mk(0,0, 1,0,1, ALL,  0,0,0, 1,0);
        vec[15] = mk(0,0, 1,0,2, RIGHT,1,0,0, 1,0);
        vec[16] = mk(0,1, 0,1,2, RIGHT,1,0,1, 1,0);
        vec[17] = mk(0,1, 0,1,2, 3'd0, 1,0,2, 1,0);
        vec[18] = mk(0,0, 1,1,2, 3'd0, 0,0,0, 1,0);
        vec[19] = mk(0,0, 1,1,1, DOWN, 0,0,0, 1,0);
        vec[20] = mk(0,0, 1,1,0, LEFT, 1,1,2, 1,0);
        vec[21] = mk(0,0, 0,0,0, LEFT, 1,1,1, 1,0);
        vec[22] = mk(0,0, 0,0,0, 3'd0, 1,1,0, 1,1);
        vec[23] = mk(0,0, 0,0,0, 3'd0, 0,0,0, 0,0);

        rst = 1'b1;
        bus_a.start = 0; bus_a.hold = 0;
        bus_b.start = 0; bus_b.hold = 0;
        bus_c.start = 0; bus_c.hold = 0;
        win_cnt[0] = 0; win_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
        mem_d[0] = '0; mem_d[1] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_a_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // ---- table-driven 5x4 ----
        for (int i = 0; i < 24; i++) begin
            bus_a.start = vec[i].start;
            bus_a.hold  = vec[i].hold;
            @(negedge clk);
            check("tbl_rd_en",   i, 32'(bus_a.rd_en),     32'(vec[i].rd_en));
            check("tbl_rd_row",  i, 32'(bus_a.rd_row),    vec[i].rd_row);
            check("tbl_rd_col",  i, 32'(bus_a.rd_col),    vec[i].rd_col);
            check("tbl_ifm",     i, 32'(bus_a.ifm_read),  32'(vec[i].ifm));
            check("tbl_wv",      i, 32'(bus_a.win_valid), 32'(vec[i].wv));
            check("tbl_win_row", i, 32'(bus_a.win_row),   vec[i].wr);
            check("tbl_win_col", i, 32'(bus_a.win_col),   vec[i].wc);
            check("tbl_busy",    i, 32'(bus_a.busy),      32'(vec[i].busy));
            check("tbl_done",    i, 32'(bus_a.done),      32'(vec[i].done));
            @(posedge clk); #1;
        end
        bus_a.start = 0; bus_a.hold = 0;
        check("tbl_done_count", 0, done_a, 2);

        // ---- reset in the 4th cycle of a scan ----
        done_ref = done_a;
        bus_a.start = 1;
        @(posedge clk); #1 bus_a.start = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_a_zero("abort");
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 0, done_a, done_ref);
        check("abort_idle", 0, 32'(bus_a.busy), 0);
        bus_a.start = 1;
        @(posedge clk); #1 bus_a.start = 0;
        @(negedge clk);
        check("restart_rd_en",  0, 32'(bus_a.rd_en), 1);
        check("restart_rd_row", 0, 32'(bus_a.rd_row), 0);
        check("restart_rd_col", 0, 32'(bus_a.rd_col), 0);
        @(negedge clk);
        check("restart_ifm", 0, 32'(bus_a.ifm_read), 32'(ALL));
        @(negedge clk);
        check("restart_wv",  0, 32'(bus_a.win_valid), 1);
        check("restart_win", 0, {16'(bus_a.win_row), 16'(bus_a.win_col)}, 0);
        for (int n = 0; n < 50 && bus_a.busy; n++) @(posedge clk);
        #1;
        check("restart_finish_busy", 0, 32'(bus_a.busy), 0);
        check("restart_done_count", 0, done_a, done_ref + 1);

        // ---- 3x5: vertical only ----
        @(posedge clk); #1;
        push_scan(0, 3, 5);
        for (int n = 0; n < 10; n++) begin
            bus_b.start = (n == 0);
            @(negedge clk);
            check("b_done", n, 32'(bus_b.done), 32'(n == 5));
            check("b_busy", n, 32'(bus_b.busy), 32'(n >= 1 && n <= 5));
            @(posedge clk); #1;
        end
        bus_b.start = 0;
        check("b_windows", 0, win_cnt[0], 3);
        check("b_done_count", 0, done_cnt[0], 1);

        // ---- 3x5 again with random back-pressure ----
        wins_ref = win_cnt[0];
        seen_busy = 1'b0;
        push_scan(0, 3, 5);
        bus_b.start = 1;
        @(posedge clk); #1 bus_b.start = 0;
        for (int n = 0; n < 200; n++) begin
            bus_b.hold = 1'($urandom_range(0, 1));
            if (bus_b.busy) seen_busy = 1'b1;
            if (seen_busy && !bus_b.busy) break;
            @(posedge clk); #1;
        end
        bus_b.hold = 0;
        check("b_hold_finished", 0, 32'(bus_b.busy), 0);
        check("b_hold_windows", 0, win_cnt[0] - wins_ref, 3);
        check("b_hold_done_count", 0, done_cnt[0], 2);
        check("b_no_horizontal", 0, bad_b, 0);
        check("b_queue_empty", 0, win_q[0].size() + cmd_q[0].size(), 0);

        // ---- default 8x8 with starts repeated while busy ----
        push_scan(1, 8, 8);
        for (int n = 0; n < 60; n++) begin
            bus_c.start = (n == 0 || n == 5 || n == 20 || n == 38);
            @(negedge clk);
            check("c_done", n, 32'(bus_c.done), 32'(n == 38));
            check("c_busy", n, 32'(bus_c.busy), 32'(n >= 1 && n <= 38));
            @(posedge clk); #1;
        end
        bus_c.start = 0;
        check("c_windows", 0, win_cnt[1], 36);
        check("c_done_count", 0, done_cnt[1], 1);
        check("c_queue_empty", 0, win_q[1].size() + cmd_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifm_scan_ctrl.md
IFM_SCAN_CTRL -- requirements
Module: ifm_scan_ctrl

Interface
REQ-001 Parameter IFM_W, default 8: input feature map width in pixels, legal range 3..255.
REQ-002 Parameter IFM_H, default 8: input feature map height in pixels, legal range 3..255.
REQ-003 Parameter IDX_W, default 8: width of all row and column index ports.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 start  in  1  one-cycle request to scan one full feature map.
REQ-007 hold  in  1  downstream back-pressure; while high, no new fetch is issued.
REQ-008 rd_en  out  1  IFM memory read strobe.
REQ-009 rd_row, rd_col  out  IDX_W each  top-left corner of the 3x3 window to fetch.
REQ-010 ifm_read  out  3  shift command to the IFM window buffer: ALL=111, RIGHT=001, DOWN=010, LEFT=100, KEEP=000.
REQ-011 win_valid  out  1  the window buffer outputs hold a new window this cycle.
REQ-012 win_row, win_col  out  IDX_W each  top-left corner of the window flagged by win_valid.
REQ-013 busy  out  1  a scan is in progress.
REQ-014 done  out  1  one-cycle pulse marking the end of the scan.

Function
REQ-015 Memory contract: one-cycle read latency; the memory returns the 3x3 window at (rd_row, rd_col), packed per row with column c in [23:16], c+1 in [15:8] and c+2 in [7:0].
REQ-016 Scan order is serpentine over (IFM_H-2)*(IFM_W-2) windows.
  - Row 0 is scanned left to right, row 1 right to left, and so on.
  - Each row change moves the window down by one.
REQ-017 Commands per fetch:
  - First window: ALL.
  - Horizontal step right: RIGHT. Horizontal step left: LEFT.
  - Vertical step: DOWN.
REQ-018 FSM states:
  - IDLE -> ISSUE on start.
  - ISSUE -> DRAIN after the last fetch is issued.
  - DRAIN -> IDLE after 2 cycles.
REQ-019 In ISSUE with hold=0, the block asserts rd_en with the next window's coordinates and advances the scan position in the same cycle.
REQ-020 In ISSUE with hold=1, rd_en=0 and the position is frozen; the scan resumes exactly where it stopped.
REQ-021 ifm_read is rd_en's command delayed 1 cycle, aligned with the returned memory data.
  - It is KEEP in any cycle that follows a cycle with rd_en=0.
REQ-022 win_valid, win_row and win_col are the fetch coordinates delayed 2 cycles.
  - win_valid is 1 exactly when ifm_read was non-KEEP in the previous cycle.
REQ-023 Latency from start to the first rd_en is 1 cycle; to the first win_valid, 3 cycles.
  - With hold never asserted, windows are produced back-to-back, one per cycle.
REQ-024 done asserts in the same cycle as the last win_valid.
  - busy is high from the cycle after start is accepted through the done cycle inclusive.
REQ-025 start while busy=1 is ignored.
REQ-026 ifm_read never takes a code outside {111,001,010,100,000}.
REQ-027 IFM_W=3: no RIGHT or LEFT is issued; the command sequence is ALL followed by IFM_H-3 DOWNs.
  - IFM_H=3: the command sequence is ALL followed by IFM_W-3 RIGHTs.
REQ-028 hold does not stall the 2-cycle output pipeline; fetches already issued still reach ifm_read and win_valid.
REQ-029 Index counters never exceed IFM_W-3 (column) or IFM_H-3 (row); there is no wrap-around within a scan.

Reset
REQ-030 While rst=1, the following are 0 and the FSM is in IDLE: rd_en, rd_row, rd_col, ifm_read (KEEP), win_valid, win_row, win_col, busy, done.
REQ-031 rst asserted mid-scan aborts the scan immediately and clears all pipeline stages; no done pulse is generated.
  - After release, the block waits for a new start.

Verification
REQ-032 IFM_W=5, IFM_H=4, start pulse, hold=0 ->
  - ifm_read sequence 111,001,001,010,100,100 on consecutive cycles.
  - win (row,col) = (0,0),(0,1),(0,2),(1,2),(1,1),(1,0).
  - done coincides with (1,0), 8 cycles after start.
REQ-033 Same map, hold=1 for 2 cycles after the third rd_en -> two KEEP cycles in ifm_read, a two-cycle gap in win_valid, identical window order, done 2 cycles later than in REQ-032.
REQ-034 IFM_W=3, IFM_H=5 -> ifm_read sequence 111,010,010; windows (0,0),(1,0),(2,0); no 001 or 100 is ever emitted.
REQ-035 start repeated while busy -> ignored: exactly one done pulse, and window count equals (W-2)*(H-2).
REQ-036 rst asserted in the 4th cycle of the scan -> all outputs 0 in that cycle, no done; a subsequent start restarts at window (0,0) with ifm_read=111.
REQ-037 Default 8x8 map -> 36 windows, with a DOWN at the end of each row and serpentine column order; a scoreboard compares each 3x3 window presented to the PE array against a software model.
